// File: rtl/pc_sel_bp_pkg.sv
// Shared opcode, funct3 and next-PC select encodings for the branch predictor slice.
// Also holds the branch-condition decode helper used at execute.
package pc_sel_bp_pkg;

    localparam logic [6:0] OPC_NOOP      = 7'b0000000;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;

    localparam logic [2:0] FNC_BEQ  = 3'b000;
    localparam logic [2:0] FNC_BNE  = 3'b001;
    localparam logic [2:0] FNC_BLT  = 3'b100;
    localparam logic [2:0] FNC_BGE  = 3'b101;
    localparam logic [2:0] FNC_BLTU = 3'b110;
    localparam logic [2:0] FNC_BGEU = 3'b111;

    localparam logic [2:0] PCSEL_HOLD    = 3'd0;
    localparam logic [2:0] PCSEL_ALU     = 3'd1;
    localparam logic [2:0] PCSEL_PC4     = 3'd2;
    localparam logic [2:0] PCSEL_PRED    = 3'd3;
    localparam logic [2:0] PCSEL_RECOVER = 3'd4;

    localparam logic [1:0] BHT_WNT = 2'b01;

    typedef struct packed {
        logic valid;
        logic taken;
    } br_res_t;

    // Unknown funct3 resolves not-taken and is flagged invalid so it is not counted.
    function automatic br_res_t resolve_branch(input logic [2:0] funct3, input logic br_eq,
                                               input logic br_lt);
        br_res_t r;
        r.valid = 1'b1;
        r.taken = 1'b0;
        case (funct3)
            FNC_BEQ:             r.taken = br_eq;
            FNC_BNE:             r.taken = !br_eq;
            FNC_BLT, FNC_BLTU:   r.taken = br_lt;
            FNC_BGE, FNC_BGEU:   r.taken = !br_lt;
            default:             r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_sel_bp_if.sv
// Fetch/execute-side bus of the next-PC selector: instruction inputs, compare flags,
// stall, and the select/flush/statistics outputs.
interface pc_sel_bp_if #(
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned CNT_W    = 32
);
    logic                stall;
    logic [31:0]         icache_dout;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [31:0]         prev_inst;
    logic                BrEq;
    logic                BrLT;
    logic [2:0]          pc_sel;
    logic                flush;
    logic                pred_taken;
    logic [CNT_W-1:0]    br_count;
    logic [CNT_W-1:0]    mispred_count;

    modport master (
        output stall, icache_dout, fetch_pc, prev_inst, BrEq, BrLT,
        input  pc_sel, flush, pred_taken, br_count, mispred_count
    );

    modport slave (
        input  stall, icache_dout, fetch_pc, prev_inst, BrEq, BrLT,
        output pc_sel, flush, pred_taken, br_count, mispred_count
    );
endinterface

// File: rtl/pc_sel_bp_bht_2bit.sv
// Bimodal table of 2-bit saturating counters: combinational read, synchronous update,
// every entry reset to weakly not-taken.
module bht_2bit
    import pc_sel_bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] cnt_q [ENTRIES];

    assign rd_cnt = cnt_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                cnt_q[i] <= BHT_WNT;
            end
        end else if (upd_en) begin
            if (upd_taken && cnt_q[upd_idx] != 2'b11) begin
                cnt_q[upd_idx] <= cnt_q[upd_idx] + 2'd1;
            end else if (!upd_taken && cnt_q[upd_idx] != 2'b00) begin
                cnt_q[upd_idx] <= cnt_q[upd_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/pc_sel_bp.sv
// Next-PC select and flush control with a bimodal predictor: predicts conditional
// branches at fetch, resolves them at execute, and keeps the JALR read-after-write hold.
module pc_sel_bp
    import pc_sel_bp_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned IDX_W       = $clog2(BHT_ENTRIES),
    parameter int unsigned CNT_W       = 32,
    parameter bit          PREDICT_EN  = 1'b1
) (
    input logic       clk,
    input logic       rst,
    pc_sel_bp_if.slave bus
);

    logic [PC_WIDTH-1:0] pc;
    logic [6:0]          opc_cur;
    logic [6:0]          opc_prev;
    logic [IDX_W-1:0]    idx;
    logic [1:0]          rd_cnt;
    br_res_t             res;
    logic                is_br;
    logic                valid_br;
    logic                actual;
    logic                mispredict;
    logic                jalr_hazard;
    logic                pred_c;

    logic [2:0]          pc_sel_c;
    logic                flush_c;
    logic                pred_out;

    logic                pred_q, pred_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    br_count_q;
    logic [CNT_W-1:0]    mispred_count_q;

    assign pc       = bus.fetch_pc;
    assign opc_cur  = bus.icache_dout[6:0];
    assign opc_prev = bus.prev_inst[6:0];
    assign idx      = pc[IDX_W+1:2];

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (idx),
        .rd_cnt    (rd_cnt),
        .upd_en    (!rst && !bus.stall && valid_br && PREDICT_EN),
        .upd_idx   (idx_q),
        .upd_taken (actual)
    );

    assign res        = resolve_branch(bus.prev_inst[14:12], bus.BrEq, bus.BrLT);
    assign is_br      = (opc_prev == OPC_BRANCH);
    assign valid_br   = is_br && res.valid;
    assign actual     = is_br && res.taken;
    assign mispredict = is_br && (actual != pred_q);
    assign pred_c     = PREDICT_EN && (opc_cur == OPC_BRANCH) && rd_cnt[1];

    // JALR reads rs1 before an older ALU/load result can reach it.
    assign jalr_hazard = (opc_cur == OPC_JALR)
                      && (bus.prev_inst[11:7] == bus.icache_dout[19:15])
                      && (opc_prev != OPC_NOOP) && (opc_prev != OPC_BRANCH)
                      && (opc_prev != OPC_STORE);

    always_comb begin
        pc_sel_c = PCSEL_PC4;
        flush_c  = 1'b0;
        pred_out = pred_c;
        if (rst) begin
            pred_out = 1'b0;
        end else if (bus.stall) begin
            pc_sel_c = PCSEL_HOLD;
        end else if (mispredict) begin
            pc_sel_c = actual ? PCSEL_ALU : PCSEL_RECOVER;
            flush_c  = 1'b1;
        end else if (jalr_hazard) begin
            pc_sel_c = PCSEL_HOLD;
        end else if (pred_c) begin
            pc_sel_c = PCSEL_PRED;
        end
    end

    // A flushed or held fetch slot enters execute as a bubble with no prediction.
    always_comb begin
        pred_d = pred_c;
        idx_d  = idx;
        if (flush_c || pc_sel_c == PCSEL_HOLD) begin
            pred_d = 1'b0;
            idx_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_q          <= 1'b0;
            idx_q           <= '0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else if (!bus.stall) begin
            pred_q <= pred_d;
            idx_q  <= idx_d;
            if (valid_br) begin
                br_count_q <= br_count_q + 1'b1;
            end
            if (mispredict) begin
                mispred_count_q <= mispred_count_q + 1'b1;
            end
        end
    end

    assign bus.pc_sel        = pc_sel_c;
    assign bus.flush         = flush_c;
    assign bus.pred_taken    = pred_out;
    assign bus.br_count      = br_count_q;
    assign bus.mispred_count = mispred_count_q;

    logic unused_bits;
    assign unused_bits = ^{pc[PC_WIDTH-1:IDX_W+2], pc[1:0], bus.prev_inst[31:15],
                           bus.icache_dout[31:20], bus.icache_dout[14:7]};

endmodule
